// File: rtl/iact_pkg.sv
// Shared types and derived constants for the input-activation scratchpad sequencer.
package iact_pkg;

    typedef enum logic [1:0] {
        LOADING = 2'd0,
        FULL    = 2'd1,
        STREAM  = 2'd2
    } iact_state_e;

    localparam int ACT_SIZE_DEF    = 5;
    localparam int KERNEL_SIZE_DEF = 3;

    // Number of valid window positions along one edge of the plane.
    function automatic int calc_out_dim(input int act_sz, input int kern_sz);
        return act_sz - kern_sz + 1;
    endfunction

    // Words streamed per plane: every window position times every kernel tap.
    function automatic int calc_beats(input int act_sz, input int kern_sz);
        int od;
        od = act_sz - kern_sz + 1;
        return od * od * kern_sz * kern_sz;
    endfunction

    localparam int OUT_DIM = calc_out_dim(ACT_SIZE_DEF, KERNEL_SIZE_DEF);
    localparam int BEATS   = calc_beats(ACT_SIZE_DEF, KERNEL_SIZE_DEF);

endpackage

// File: rtl/spad_mem.sv
// Activation scratchpad storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every plane is fully rewritten before use.
module spad_mem #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming word when strobed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iact_spad_seq.sv
// Loads one activation plane into the scratchpad, then streams every convolution
// window (oy, ox outer; ky, kx inner) to the PE over a valid/ready link.
//
// Handshake: a beat transfers on a rising edge where iact_valid && iact_ready.
// iact_valid, iact_data and iact_last are registers; once valid is high they hold
// until the beat transfers, and the next word is presented on the following cycle.
module iact_spad_seq
    import iact_pkg::*;
#(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int kernel_size        = 3,
    parameter int act_size           = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITWIDTH-1:0] w_data_spad,
    input  logic                     load_en_spad,
    output logic                     load_done,
    input  logic                     start_stream,
    output logic [DATA_BITWIDTH-1:0] iact_data,
    output logic                     iact_valid,
    input  logic                     iact_ready,
    output logic                     iact_last,
    output logic                     overflow,
    output iact_state_e              state_dbg
);

    localparam int AW        = ADDR_BITWIDTH_SPAD;
    localparam int OUT_DIM_P = calc_out_dim(act_size, kernel_size);

    localparam logic [AW-1:0] ACT_A    = AW'(act_size);
    localparam logic [AW-1:0] K_MAX    = AW'(kernel_size - 1);
    localparam logic [AW-1:0] O_MAX    = AW'(OUT_DIM_P - 1);
    localparam logic [AW-1:0] AREA_MAX = AW'(act_size * act_size - 1);

    iact_state_e             state_q;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           oy_q, ox_q, ky_q, kx_q;
    logic [AW-1:0]           oy_d, ox_d, ky_d, kx_d;
    logic [DATA_BITWIDTH-1:0] data_q;
    logic                    valid_q, last_q, ovf_q;

    logic [AW-1:0]            rd_addr;
    logic [DATA_BITWIDTH-1:0] rd_data;
    logic                     mem_we;
    logic                     is_final;

    assign mem_we   = (state_q == LOADING) && load_en_spad;
    assign rd_addr  = (oy_q + ky_q) * ACT_A + (ox_q + kx_q);
    assign is_final = (oy_q == O_MAX) && (ox_q == O_MAX) && (ky_q == K_MAX) && (kx_q == K_MAX);

    spad_mem #(
        .WIDTH  (DATA_BITWIDTH),
        .ADDR_W (AW)
    ) u_spad_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_data_spad),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next window/tap indices: kx fastest, oy slowest, wrapping to 0 after the final tap.
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (kx_q != K_MAX) begin
            kx_d = kx_q + 1'b1;
        end else begin
            kx_d = '0;
            if (ky_q != K_MAX) begin
                ky_d = ky_q + 1'b1;
            end else begin
                ky_d = '0;
                if (ox_q != O_MAX) begin
                    ox_d = ox_q + 1'b1;
                end else begin
                    ox_d = '0;
                    oy_d = (oy_q != O_MAX) ? oy_q + 1'b1 : '0;
                end
            end
        end
    end

    // Load / full / stream sequencer with registered stream outputs and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOADING;
            wr_ptr_q <= '0;
            oy_q     <= '0;
            ox_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (load_en_spad && (state_q != LOADING)) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                LOADING: begin
                    if (load_en_spad) begin
                        if (wr_ptr_q == AREA_MAX) begin
                            wr_ptr_q <= '0;
                            state_q  <= FULL;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (start_stream) begin
                        state_q <= STREAM;
                        oy_q    <= '0;
                        ox_q    <= '0;
                        ky_q    <= '0;
                        kx_q    <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (valid_q && iact_ready && last_q) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= LOADING;
                    end else if (!valid_q || iact_ready) begin
                        data_q  <= rd_data;
                        valid_q <= 1'b1;
                        last_q  <= is_final;
                        oy_q    <= oy_d;
                        ox_q    <= ox_d;
                        ky_q    <= ky_d;
                        kx_q    <= kx_d;
                    end
                end
                default: state_q <= LOADING;
            endcase
        end
    end

    assign load_done  = (state_q == FULL);
    assign iact_data  = data_q;
    assign iact_valid = valid_q;
    assign iact_last  = last_q;
    assign overflow   = ovf_q;
    assign state_dbg  = state_q;

endmodule
